mod3_check_arbiter: RTL and testbench

Two-requester front end for the serial divisible-by-3 checker. Accepts parallel words from two requesters and arbitrates between them. Serializes the granted word MSB-first through an internal mod-3 residue state machine, then returns a one-cycle result pulse tagged with the owning requester. Sits between parallel producers and the serial mod-3 datapath, so that datapath can be shared without contention.

---
 rtl/mod3_check_arbiter.sv | 146 ++++++++++++++
 tb/tb_mod3_check_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mod3_check_arbiter.sv
// Two-requester front end for a serial MSB-first divisible-by-3 checker.
// Define MOD3_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module mod3_check_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             ser_bit,
  output logic             ser_vld,
  output logic             done,
  output logic             div3,
  output logic             owner
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       res_q, res_d;
  logic [1:0]       res_nxt;
  logic             cur_owner_q, cur_owner_d;
  logic             owner_q, owner_d;
  logic             div3_q, div3_d;
  logic             done_q, done_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             win1;

`ifdef MOD3_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // ptr_q = 1 means requester 1 wins a tie
  assign win1 = req1 & (~req0 | ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && (req0 || req1)) ptr_d = ~win1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign win1 = req1 & ~req0;
`endif

  // (2*res + bit) mod 3, residue restricted to 0..2
  always_comb begin
    case ({res_q, shreg_q[WIDTH-1]})
      3'b000:  res_nxt = 2'd0;
      3'b001:  res_nxt = 2'd1;
      3'b010:  res_nxt = 2'd2;
      3'b011:  res_nxt = 2'd0;
      3'b100:  res_nxt = 2'd1;
      3'b101:  res_nxt = 2'd2;
      default: res_nxt = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    cur_owner_d = cur_owner_q;
    owner_d     = owner_q;
    div3_d      = div3_q;
    done_d      = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          shreg_d     = win1 ? data1 : data0;
          gnt0_d      = ~win1;
          gnt1_d      = win1;
          cur_owner_d = win1;
          res_d       = 2'd0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = res_nxt;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          div3_d  = (res_nxt == 2'd0);
          // owner only changes with a new result so it holds between dones
          owner_d = cur_owner_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      res_q       <= 2'd0;
      cur_owner_q <= 1'b0;
      owner_q     <= 1'b0;
      div3_q      <= 1'b0;
      done_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      cur_owner_q <= cur_owner_d;
      owner_q     <= owner_d;
      div3_q      <= div3_d;
      done_q      <= done_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = (state_q != IDLE);
  assign ser_vld = (state_q == SHIFT);
  assign ser_bit = (state_q == SHIFT) & shreg_q[WIDTH-1];
  assign done    = done_q;
  assign div3    = div3_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_mod3_check_arbiter.sv
// Directed, table-driven bench for mod3_check_arbiter (WIDTH=8), both arbitration builds.
module tb_mod3_check_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         gnt0, gnt1, busy, ser_bit, ser_vld, done, div3, owner;

  mod3_check_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .ser_bit(ser_bit), .ser_vld(ser_vld),
    .done(done), .div3(div3), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         exp_owner;
    logic         exp_div3;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_word(input vec_t v, input int idx);
    logic [W-1:0] bits;
    logic [W-1:0] exp_bits;
    int           nvld;
    int           cycles;
    logic         got_done;
    logic         held_div3;
    logic         held_owner;
    exp_bits = v.exp_owner ? v.d1 : v.d0;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
    @(negedge clk);
    check("gnt0", gnt0, !v.exp_owner);
    check("gnt1", gnt1, v.exp_owner);
    check("busy_after_accept", busy, 1);
    req0 = 1'b0; req1 = 1'b0; data0 = ~v.d0; data1 = ~v.d1;
    bits = '0; nvld = 0; cycles = 0; got_done = 1'b0;
    while (!got_done && cycles < 40) begin
      if (ser_vld) begin
        bits = {bits[W-2:0], ser_bit};
        nvld++;
      end
      if (done) got_done = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
        if (cycles == 1) check("gnt_one_cycle", {gnt0, gnt1}, 0);
      end
    end
    check("done_seen", got_done, 1);
    check("done_latency", cycles, W);
    check("ser_vld_cycles", nvld, W);
    check("ser_bits", bits, exp_bits);
    check("div3", div3, v.exp_div3);
    check("owner", owner, v.exp_owner);
    held_div3 = div3; held_owner = owner;
    $display("word %0d: owner=%0d div3=%0d latency=%0d bits=%02h", idx, owner, div3, cycles, bits);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("idle_after_done", busy, 0);
    check("div3_hold", div3, v.exp_div3);
    check("owner_hold", owner, v.exp_owner);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_own[4];
    int   ndone;
    int   cyc;
    int   last_cyc;
    vec_t v_rst;

    vecs[0] = '{1'b1, 1'b0, 8'd9,   8'd0,  1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 8'd0,   8'd10, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'hA5,  8'd0,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'd255, 8'd0,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'd254, 8'd0,  1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'd0,   8'h80, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'd0,   8'd3,  1'b1, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_outputs", {gnt0, gnt1, busy, ser_bit, ser_vld, done, div3, owner}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_req", busy, 0);

    for (int i = 0; i < 8; i++) run_word(vecs[i], i);

`ifdef MOD3_ROUND_ROBIN_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    // Both requesters held high: data0=3 (div3) and data1=7 (not div3)
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'd3; data1 = 8'd7;
    ndone = 0; cyc = 0; last_cyc = 0;
    while (ndone < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (gnt0 && gnt1) check("dual_gnt", {gnt0, gnt1}, 2'b01);
      if (done) begin
        check("both_owner", owner, exp_own[ndone]);
        check("both_div3", div3, !exp_own[ndone]);
        if (ndone > 0) check("both_spacing", cyc - last_cyc, W + 2);
        $display("both word %0d: owner=%0d div3=%0d cycle=%0d", ndone, owner, div3, cyc);
        last_cyc = cyc;
        ndone++;
        if (ndone == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    check("both_done_count", ndone, 4);
    @(negedge clk);
    check("both_idle", busy, 0);
    @(negedge clk);
    check("both_no_accept", busy, 0);

    // Reset on the third SHIFT cycle
    req0 = 1'b1; data0 = 8'd9;
    @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_outputs", {gnt0, gnt1, busy, ser_bit, ser_vld, done, div3, owner}, 0);
    $display("reset applied mid-SHIFT: busy=%0d done=%0d", busy, done);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_done", {busy, done}, 0);
    end
    v_rst = '{1'b0, 1'b1, 8'd0, 8'd6, 1'b1, 1'b1};
    run_word(v_rst, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
